sram_dp_be: RTL

Parametrised simple dual-port SRAM (one read port, one write port) with per-byte write enables, a selectable read latency of 1 or 2 cycles, and a read-valid strobe. It is the next-generation local buffer for datapath blocks that need partial-word updates and a registered output for timing closure. It is a drop-in for the earlier 8-bit single-latency SRAM when BYTE_WIDTH = DATA_WIDTH and OUT_REG = 0.

---
 rtl/sram_dp_be_pkg.sv | 15 +
 rtl/sram_be_merge.sv | 27 ++
 rtl/sram_dp_be.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sram_dp_be_pkg.sv
// Shared constants for the byte-enable dual-port SRAM: enable levels, reset level,
// and the address-index width helper.
package sram_dp_be_pkg;

  localparam logic ChipEnable  = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;
  localparam logic RstActive   = 1'b0;

  // Index width that addresses DATA_DEPTH words; never below one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_be_merge.sv
// Combinational byte-lane merge: lanes with wbe[k]=1 take new_word, the rest keep old_word.
module sram_be_merge #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]            old_word,
  input  logic [DATA_WIDTH-1:0]            new_word,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
  output logic [DATA_WIDTH-1:0]            merged
);
  import sram_dp_be_pkg::*;

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  // Per-lane select between the stored and the incoming byte.
  always_comb begin
    merged = old_word;
    for (int k = 0; k < NB; k++) begin
      if (wbe[k]) begin
        merged[k*BYTE_WIDTH +: BYTE_WIDTH] = new_word[k*BYTE_WIDTH +: BYTE_WIDTH];
      end else begin
        merged[k*BYTE_WIDTH +: BYTE_WIDTH] = old_word[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

endmodule

// File: rtl/sram_dp_be.sv
// Simple dual-port SRAM with byte-lane write enables and read latency 1 or 2 (OUT_REG).
// Define SRAM_BYPASS_EN for write-first collisions; read-first otherwise.
module sram_dp_be #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int OUT_REG    = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ce,
  input  logic [ADDR_WIDTH-1:0]           raddr,
  input  logic                            re,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            rvalid,
  input  logic [ADDR_WIDTH-1:0]           waddr,
  input  logic                            we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]           wdata
);
  import sram_dp_be_pkg::*;

  localparam int IDXW      = idx_width(DATA_DEPTH);
  localparam int MEM_WORDS = 2 ** IDXW;

  logic [DATA_WIDTH-1:0] mem_r [MEM_WORDS];
  logic [DATA_WIDTH-1:0] wmerged_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [DATA_WIDTH-1:0] s1_data_r;
  logic                  s1_valid_r;
  logic [IDXW-1:0]       widx_s;
  logic [IDXW-1:0]       ridx_s;
  logic                  waddr_ok_s;
  logic                  raddr_ok_s;
  logic                  wr_en_s;
  logic                  rd_en_s;

  // Addresses at or above DATA_DEPTH never touch the array.
  assign waddr_ok_s = (32'(waddr) < 32'(DATA_DEPTH));
  assign raddr_ok_s = (32'(raddr) < 32'(DATA_DEPTH));
  assign widx_s     = waddr[IDXW-1:0];
  assign ridx_s     = raddr[IDXW-1:0];
  assign wr_en_s    = (ce == ChipEnable) && (we == WriteEnable) && waddr_ok_s;
  assign rd_en_s    = (ce == ChipEnable) && (re == ReadEnable);

  sram_be_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_merge (
    .old_word (mem_r[widx_s]),
    .new_word (wdata),
    .wbe      (wbe),
    .merged   (wmerged_s)
  );

  // Read word selection, including the optional same-address bypass.
  always_comb begin
    rd_word_s = {DATA_WIDTH{1'b0}};
    if (!raddr_ok_s) begin
      rd_word_s = {DATA_WIDTH{1'b0}};
    end
`ifdef SRAM_BYPASS_EN
    else if (wr_en_s && (waddr == raddr)) begin
      rd_word_s = wmerged_s;
    end
`endif
    else begin
      rd_word_s = mem_r[ridx_s];
    end
  end

  // Memory array: cleared on reset, byte-merged update on write.
  always_ff @(posedge clk) begin
    if (rst == RstActive) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[widx_s] <= wmerged_s;
    end
  end

  // Stage 1: capture the read word; data holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst == RstActive) begin
      s1_data_r  <= {DATA_WIDTH{1'b0}};
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= rd_en_s;
      if (rd_en_s) begin
        s1_data_r <= rd_word_s;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_data_r;
      logic                  s2_valid_r;

      // Stage 2 runs regardless of ce so an in-flight read always completes.
      always_ff @(posedge clk) begin
        if (rst == RstActive) begin
          s2_data_r  <= {DATA_WIDTH{1'b0}};
          s2_valid_r <= 1'b0;
        end else begin
          s2_valid_r <= s1_valid_r;
          if (s1_valid_r) begin
            s2_data_r <= s1_data_r;
          end
        end
      end

      assign rdata  = s2_data_r;
      assign rvalid = s2_valid_r;
    end else begin : g_out_direct
      assign rdata  = s1_data_r;
      assign rvalid = s1_valid_r;
    end
  endgenerate

endmodule
